// File: rtl/axis_video_burst_gen.sv
// rtl/axis_video_burst_gen.sv - AXI4-Stream video frame source emitting pixel bursts separated by idle gaps
module axis_video_burst_gen #(
    parameter int DATA_W    = 32,
    parameter int PIX       = 640,
    parameter int LINES     = 480,
    parameter int BURST_LEN = 4,
    parameter int BURST_GAP = 3,
    parameter int LINE_GAP  = 1750,
    parameter int FRAME_GAP = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_data,
    output logic [DATA_W-1:0] m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    input  logic              m_axis_video_tready,
    output logic              m_axis_video_tlast,
    output logic              m_axis_video_tuser,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int X_W     = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int Y_W     = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int B_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GAP_MAX = (BURST_GAP > LINE_GAP)
                           ? ((BURST_GAP > FRAME_GAP) ? BURST_GAP : FRAME_GAP)
                           : ((LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP);
    localparam int G_W     = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;

    localparam logic [X_W-1:0] X_LAST  = X_W'(PIX - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(LINES - 1);
    localparam logic [B_W-1:0] B_LAST  = B_W'(BURST_LEN - 1);
    localparam logic [G_W-1:0] BG_LAST = G_W'((BURST_GAP > 0) ? BURST_GAP - 1 : 0);
    localparam logic [G_W-1:0] LG_LAST = G_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic [G_W-1:0] FG_LAST = G_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BURST,
        S_GAP,
        S_LGAP,
        S_FGAP
    } state_t;

    state_t            state, state_n;
    logic [X_W-1:0]    x, x_n;
    logic [Y_W-1:0]    y, y_n;
    logic [B_W-1:0]    bcnt, bcnt_n;
    logic [G_W-1:0]    gcnt, gcnt_n;
    logic [1:0]        mode_r, mode_n;
    logic [DATA_W-1:0] const_r, const_n;
    logic [7:0]        f_r, f_n;
    logic [15:0]       frame_cnt_n;
    logic              line_done, frame_done, start_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            x         <= '0;
            y         <= '0;
            bcnt      <= '0;
            gcnt      <= '0;
            mode_r    <= '0;
            const_r   <= '0;
            f_r       <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            bcnt      <= bcnt_n;
            gcnt      <= gcnt_n;
            mode_r    <= mode_n;
            const_r   <= const_n;
            f_r       <= f_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        x_n         = x;
        y_n         = y;
        bcnt_n      = bcnt;
        gcnt_n      = gcnt;
        mode_n      = mode_r;
        const_n     = const_r;
        f_n         = f_r;
        frame_cnt_n = frame_cnt;
        line_done   = 1'b0;
        frame_done  = 1'b0;
        start_frame = 1'b0;

        case (state)
            S_IDLE: begin
                if (enable) start_frame = 1'b1;
            end
            S_BURST: begin
                if (m_axis_video_tready) begin
                    if (x == X_LAST) begin
                        // Line end always restarts the burst count, even mid-burst
                        x_n    = '0;
                        bcnt_n = '0;
                        if (LINE_GAP > 0) begin
                            state_n = S_LGAP;
                            gcnt_n  = '0;
                        end else begin
                            line_done = 1'b1;
                        end
                    end else begin
                        x_n = x + X_W'(1);
                        if (bcnt == B_LAST) begin
                            bcnt_n = '0;
                            if (BURST_GAP > 0) begin
                                state_n = S_GAP;
                                gcnt_n  = '0;
                            end
                        end else begin
                            bcnt_n = bcnt + B_W'(1);
                        end
                    end
                end
            end
            S_GAP: begin
                if (gcnt == BG_LAST) begin
                    state_n = S_BURST;
                    gcnt_n  = '0;
                end else begin
                    gcnt_n = gcnt + G_W'(1);
                end
            end
            S_LGAP: begin
                if (gcnt == LG_LAST) begin
                    gcnt_n    = '0;
                    line_done = 1'b1;
                end else begin
                    gcnt_n = gcnt + G_W'(1);
                end
            end
            S_FGAP: begin
                if (gcnt == FG_LAST) begin
                    gcnt_n     = '0;
                    frame_done = 1'b1;
                end else begin
                    gcnt_n = gcnt + G_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (line_done) begin
            if (y == Y_LAST) begin
                frame_cnt_n = frame_cnt + 16'd1;
                if (FRAME_GAP > 0) begin
                    state_n = S_FGAP;
                    gcnt_n  = '0;
                end else begin
                    frame_done = 1'b1;
                end
            end else begin
                y_n     = y + Y_W'(1);
                state_n = S_BURST;
            end
        end

        if (frame_done) begin
            if (enable) start_frame = 1'b1;
            else        state_n     = S_IDLE;
        end

        // Pattern inputs are captured once so the whole frame uses a consistent source
        if (start_frame) begin
            state_n = S_BURST;
            x_n     = '0;
            y_n     = '0;
            bcnt_n  = '0;
            gcnt_n  = '0;
            mode_n  = mode;
            const_n = const_data;
            f_n     = frame_cnt_n[7:0];
        end
    end

    logic [15:0] x16, y16;
    logic [11:0] x12, y12;

    always_comb begin
        x16 = 16'(x);
        y16 = 16'(y);
        x12 = 12'(x);
        y12 = 12'(y);
        case (mode_r)
            2'd0:    m_axis_video_tdata = DATA_W'(x);
            2'd1:    m_axis_video_tdata = DATA_W'({y16, x16});
            2'd2:    m_axis_video_tdata = const_r;
            default: m_axis_video_tdata = DATA_W'({f_r, y12, x12});
        endcase
    end

    assign m_axis_video_tvalid = (state == S_BURST);
    assign m_axis_video_tlast  = m_axis_video_tvalid && (x == X_LAST);
    assign m_axis_video_tuser  = m_axis_video_tvalid && (x == '0) && (y == '0);
    assign busy                = (state != S_IDLE);

endmodule

// File: tb/tb_axis_video_burst_gen.sv
// tb/tb_axis_video_burst_gen.sv - directed self-checking bench for axis_video_burst_gen
module tb_axis_video_burst_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, tready;
    logic [1:0]  mode;
    logic [31:0] const_data;
    logic [31:0] tdata, tdata6;
    logic        tvalid, tlast, tuser, busy;
    logic        tvalid6, tlast6, tuser6, busy6;
    logic [15:0] fcnt, fcnt6;

    int total = 0;
    int bad   = 0;
    int sched[$];

    axis_video_burst_gen #(
        .DATA_W(32), .PIX(8), .LINES(2), .BURST_LEN(4),
        .BURST_GAP(3), .LINE_GAP(5), .FRAME_GAP(2)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .const_data(const_data),
        .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
        .m_axis_video_tready(tready), .m_axis_video_tlast(tlast),
        .m_axis_video_tuser(tuser), .busy(busy), .frame_cnt(fcnt)
    );

    axis_video_burst_gen #(
        .DATA_W(32), .PIX(6), .LINES(2), .BURST_LEN(4),
        .BURST_GAP(3), .LINE_GAP(5), .FRAME_GAP(2)
    ) u_dut6 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .const_data(const_data),
        .m_axis_video_tdata(tdata6), .m_axis_video_tvalid(tvalid6),
        .m_axis_video_tready(tready), .m_axis_video_tlast(tlast6),
        .m_axis_video_tuser(tuser6), .busy(busy6), .frame_cnt(fcnt6)
    );

    // Expected cycle schedule for one 2-line frame: -1 idle, else y*256+x
    task automatic build_sched(input int pix);
        sched.delete();
        for (int yy = 0; yy < 2; yy++) begin
            int xx;
            xx = 0;
            while (xx < pix) begin
                int n;
                n = (pix - xx < 4) ? pix - xx : 4;
                for (int k = 0; k < n; k++) sched.push_back(yy * 256 + xx + k);
                xx += n;
                if (xx < pix) repeat (3) sched.push_back(-1);
            end
            repeat (5) sched.push_back(-1);
            if (yy == 1) repeat (2) sched.push_back(-1);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; mode = 2'd0; const_data = 32'h0; tready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
        total++; if (tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %h want 0", tdata); end
        total++; if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", tlast); end
        total++; if (tuser !== 1'b0) begin bad++; $display("FAIL reset_tuser: got %b want 0", tuser); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (fcnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt: got %0d want 0", fcnt); end
        rst = 1'b0;
    endtask

    task automatic test_frame();
        int e, x, y;
        build_sched(8);
        @(negedge clk);
        enable = 1'b1; mode = 2'd0; tready = 1'b1;
        foreach (sched[i]) begin
            @(negedge clk);
            e = sched[i];
            if (e < 0) begin
                total++;
                if (tvalid !== 1'b0) begin bad++; $display("FAIL t1_idle[%0d]: got tvalid %b want 0", i, tvalid); end
            end else begin
                x = e % 256; y = e / 256;
                total++;
                if (tvalid !== 1'b1) begin bad++; $display("FAIL t1_valid[%0d]: got %b want 1", i, tvalid); end
                total++;
                if (tdata !== 32'(x)) begin bad++; $display("FAIL t1_tdata[%0d]: got %h want %h", i, tdata, 32'(x)); end
                total++;
                if ({tlast, tuser} !== {(x == 7), (x == 0 && y == 0)})
                    begin bad++; $display("FAIL t1_markers[%0d]: got last/user %b%b want %b%b", i, tlast, tuser, (x == 7), (x == 0 && y == 0)); end
            end
            if (i == 5) mode = 2'd3;
        end
        total++; if (fcnt !== 16'd1) begin bad++; $display("FAIL t1_frame_cnt: got %0d want 1", fcnt); end
    endtask

    task automatic test_mode_switch();
        int n;
        @(negedge clk);
        total++; if ({tvalid, tuser} !== 2'b11) begin bad++; $display("FAIL t5_sof: got valid/user %b%b want 11", tvalid, tuser); end
        total++; if (tdata !== 32'h0100_0000) begin bad++; $display("FAIL t5_tdata0: got %h want 01000000", tdata); end
        enable = 1'b0;
        @(negedge clk);
        total++; if (tdata !== 32'h0100_0001) begin bad++; $display("FAIL t5_tdata1: got %h want 01000001", tdata); end
        n = 0;
        while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_drain: busy still %b after %0d cycles", busy, n); end
        total++; if (fcnt !== 16'd2) begin bad++; $display("FAIL t5_frame_cnt: got %0d want 2", fcnt); end
    endtask

    task automatic test_stall();
        int pat[4] = '{1, 0, 0, 1};
        int want_runs[4] = '{3, 5, 3, 7};
        int runs[$];
        int beats, idle, cyc, x, y;
        bit seen, done, prev_stall;
        logic [31:0] pd;
        logic pl, pu;
        beats = 0; idle = 0; cyc = 0; seen = 0; done = 0; prev_stall = 0;
        pd = '0; pl = 0; pu = 0;
        pulse_reset();
        enable = 1'b1; mode = 2'd0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            tready = pat[cyc % 4][0];
            cyc++;
            enable = 1'b0;
            if (prev_stall) begin
                total++;
                if ({tvalid, tdata, tlast, tuser} !== {1'b1, pd, pl, pu})
                    begin bad++; $display("FAIL t2_hold: got v%b d%h l%b u%b want v1 d%h l%b u%b", tvalid, tdata, tlast, tuser, pd, pl, pu); end
            end
            if (tvalid === 1'b1) begin
                if (seen && idle > 0) runs.push_back(idle);
                idle = 0; seen = 1;
                if (tready) begin
                    x = beats % 8; y = beats / 8;
                    total++;
                    if ({tdata, tlast, tuser} !== {32'(x), (x == 7), (x == 0 && y == 0)})
                        begin bad++; $display("FAIL t2_beat%0d: got d%h l%b u%b want d%h l%b u%b", beats, tdata, tlast, tuser, 32'(x), (x == 7), (x == 0 && y == 0)); end
                    beats++;
                end
            end else if (seen && busy === 1'b1) begin
                idle++;
            end
            if (seen && busy === 1'b0) done = 1;
            prev_stall = tvalid && !tready;
            pd = tdata; pl = tlast; pu = tuser;
        end
        if (idle > 0) runs.push_back(idle);
        tready = 1'b1;
        total++; if (!done) begin bad++; $display("FAIL t2_timeout: got %0d cycles want frame end", cyc); end
        total++; if (beats != 16) begin bad++; $display("FAIL t2_beats: got %0d want 16", beats); end
        total++;
        if (runs.size() != 4) begin bad++; $display("FAIL t2_runs: got %0d gaps want 4", runs.size()); end
        else foreach (want_runs[i]) begin
            total++;
            if (runs[i] != want_runs[i]) begin bad++; $display("FAIL t2_gap%0d: got %0d want %0d", i, runs[i], want_runs[i]); end
        end
    endtask

    task automatic test_short_line();
        int e, x, y;
        build_sched(6);
        pulse_reset();
        enable = 1'b1; mode = 2'd0; tready = 1'b1;
        foreach (sched[i]) begin
            @(negedge clk);
            enable = 1'b0;
            e = sched[i];
            if (e < 0) begin
                total++;
                if (tvalid6 !== 1'b0) begin bad++; $display("FAIL t3_idle[%0d]: got tvalid %b want 0", i, tvalid6); end
            end else begin
                x = e % 256; y = e / 256;
                total++;
                if ({tvalid6, tdata6, tlast6, tuser6} !== {1'b1, 32'(x), (x == 5), (x == 0 && y == 0)})
                    begin bad++; $display("FAIL t3_beat[%0d]: got v%b d%h l%b u%b want v1 d%h l%b u%b", i, tvalid6, tdata6, tlast6, tuser6, 32'(x), (x == 5), (x == 0 && y == 0)); end
            end
        end
        @(negedge clk);
        total++; if ({busy6, fcnt6} !== {1'b0, 16'd1}) begin bad++; $display("FAIL t3_end: got busy %b cnt %0d want 0 1", busy6, fcnt6); end
    endtask

    task automatic test_enable_drop();
        int beats, n;
        bit seen, extra;
        beats = 0; n = 0; seen = 0; extra = 0;
        pulse_reset();
        enable = 1'b1; mode = 2'd0; tready = 1'b1;
        while (!(seen && busy === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
            if (tvalid === 1'b1) begin
                seen = 1;
                beats++;
                if (beats == 2) enable = 1'b0;
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_timeout: busy %b after %0d cycles", busy, n); end
        total++; if (beats != 16) begin bad++; $display("FAIL t4_beats: got %0d want 16", beats); end
        total++; if (fcnt !== 16'd1) begin bad++; $display("FAIL t4_frame_cnt: got %0d want 1", fcnt); end
        repeat (20) begin
            @(negedge clk);
            if (tvalid !== 1'b0 || busy !== 1'b0) extra = 1;
        end
        total++; if (extra) begin bad++; $display("FAIL t4_quiet: got activity after IDLE want none"); end
    endtask

    task automatic test_reset_mid();
        int n;
        enable = 1'b1; tready = 1'b1; mode = 2'd0;
        @(negedge clk);
        @(negedge clk);
        tready = 1'b0;
        @(negedge clk);
        total++;
        if ({tvalid, tdata, tuser} !== {1'b1, 32'h1, 1'b0})
            begin bad++; $display("FAIL t6_stall: got v%b d%h u%b want v1 d00000001 u0", tvalid, tdata, tuser); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({tvalid, tdata, tlast, tuser, busy} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0})
            begin bad++; $display("FAIL t6_outputs: got v%b d%h l%b u%b b%b want all 0", tvalid, tdata, tlast, tuser, busy); end
        total++; if (fcnt !== 16'd0) begin bad++; $display("FAIL t6_frame_cnt: got %0d want 0", fcnt); end
        rst = 1'b0; tready = 1'b1;
        @(negedge clk);
        total++;
        if ({tvalid, tuser, tdata} !== {1'b1, 1'b1, 32'h0})
            begin bad++; $display("FAIL t6_restart: got v%b u%b d%h want v1 u1 d0", tvalid, tuser, tdata); end
        enable = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_drain: busy %b after %0d cycles", busy, n); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_mode_switch();
        test_stall();
        test_short_line();
        test_enable_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
